// File: rtl/sense_event_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sense_event_pkg
// Purpose  : Shared definitions for the sense_event_unit change-sense block:
//            event-mode encodings and the per-channel event detect function.
// Contents : MODE_ANY / MODE_RISE / MODE_FALL / MODE_OFF, DETECT_W, detect()
// Revision : 1.0 - initial release
// ============================================================================
package sense_event_pkg;

    localparam logic [1:0] MODE_ANY  = 2'd0;
    localparam logic [1:0] MODE_RISE = 2'd1;
    localparam logic [1:0] MODE_FALL = 2'd2;
    localparam logic [1:0] MODE_OFF  = 2'd3;

    // Callers zero-extend channel samples to this width. Zero padding never
    // creates a spurious change, rise or fall.
    localparam int DETECT_W = 32;

    function automatic logic detect(input logic [DETECT_W-1:0] prev,
                                    input logic [DETECT_W-1:0] cur,
                                    input logic [1:0]          mode);
        logic ev;
        ev = 1'b0;
        case (mode)
            MODE_ANY:  ev = (prev != cur);
            MODE_RISE: ev = |(~prev & cur);
            MODE_FALL: ev = |(prev & ~cur);
            default:   ev = 1'b0;
        endcase
        return ev;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sense_event_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sense_event_fifo
// Purpose  : DEPTH-entry record FIFO with registered storage. The head entry
//            is presented whenever valid; simultaneous push and pop are
//            accepted even when full.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            push, push_data  - write request and record
//            full             - no free entry
//            pop              - consumer accepts head (ignored when empty)
//            valid, head_data - head record
//            count            - occupancy, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module sense_event_fifo #(
    parameter int WIDTH_REC = 4,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH_REC-1:0]       push_data,
    output logic                       full,
    input  logic                       pop,
    output logic                       valid,
    output logic [WIDTH_REC-1:0]       head_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH_REC-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr;
    logic [AW-1:0]        r_rd;
    logic [AW:0]          r_count;
    logic                 w_pop;
    logic                 w_push;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign valid     = (r_count != '0);
    assign head_data = r_mem[r_rd];
    assign count     = r_count;

    // When full, a write to r_wr lands on the slot being popped this cycle,
    // which is safe because the head has already been consumed.
    assign w_pop  = pop && valid;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= push_data;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sense_event_unit.sv
`default_nettype none
// ============================================================================
// Module   : sense_event_unit
// Purpose  : Multi-channel change-sense block. Samples CHANNELS groups of
//            WIDTH bits per clock, detects per-channel events (any change,
//            rising or falling), holds one pending value per channel and
//            queues {channel, data} records into a FIFO in ascending channel
//            priority.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_data             - channel c at [c*WIDTH +: WIDTH]
//            mode, invert        - event mode, complement record data
//            out_valid/out_ready - record handshake
//            out_chan, out_data  - head record
//            out_count           - FIFO occupancy
//            coal_count          - coalesced-event count (optional)
// Config   : define SENSE_EVENT_STATS_EN to add the coal_count port/counter.
// Revision : 1.0 - initial release
// ============================================================================
module sense_event_unit
    import sense_event_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS*WIDTH-1:0]     in_data,
    input  logic [1:0]                    mode,
    input  logic                          invert,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(CHANNELS)-1:0]   out_chan,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(DEPTH):0]        out_count
`ifdef SENSE_EVENT_STATS_EN
    ,
    output logic [15:0]                   coal_count
`endif
);
    localparam int CW    = $clog2(CHANNELS);
    localparam int REC_W = CW + WIDTH;

    logic [CHANNELS*WIDTH-1:0] r_prev;
    logic                      r_primed;
    logic [CHANNELS-1:0]       r_pending;
    logic [WIDTH-1:0]          r_pval [CHANNELS];

    logic [CHANNELS-1:0]       w_event;
    logic [CHANNELS-1:0]       w_grant_vec;
    logic                      w_grant;
    logic [CW-1:0]             w_grant_idx;
    logic                      w_full;
    logic                      w_pop;
    logic [REC_W-1:0]          w_push_data;
    logic [REC_W-1:0]          w_head;

    // Event detection is suppressed until one sample has been taken since
    // reset, so the reset value of r_prev never produces an event.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_detect
        assign w_event[c] = r_primed &&
            detect({{(DETECT_W-WIDTH){1'b0}}, r_prev[c*WIDTH +: WIDTH]},
                   {{(DETECT_W-WIDTH){1'b0}}, in_data[c*WIDTH +: WIDTH]},
                   mode);
    end

    assign w_pop = out_valid && out_ready;

    // Fixed-priority arbiter: lowest pending index wins. A full FIFO can
    // still take a record when the head is popped in the same cycle.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_grant_vec = '0;
        for (int c = CHANNELS-1; c >= 0; c--) begin
            if (r_pending[c]) begin
                w_grant     = 1'b1;
                w_grant_idx = CW'(c);
            end
        end
        if (w_full && !w_pop) w_grant = 1'b0;
        if (w_grant) w_grant_vec[w_grant_idx] = 1'b1;
    end

    assign w_push_data = {w_grant_idx, r_pval[w_grant_idx]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev    <= '0;
            r_primed  <= 1'b0;
            r_pending <= '0;
            for (int c = 0; c < CHANNELS; c++) r_pval[c] <= '0;
        end else begin
            r_prev   <= in_data;
            r_primed <= 1'b1;
            for (int c = 0; c < CHANNELS; c++) begin
                // A new event outranks a grant: the pushed record carries the
                // old value and the new value stays pending.
                if (w_event[c]) begin
                    r_pending[c] <= 1'b1;
                    r_pval[c]    <= in_data[c*WIDTH +: WIDTH] ^ {WIDTH{invert}};
                end else if (w_grant_vec[c]) begin
                    r_pending[c] <= 1'b0;
                end
            end
        end
    end

    sense_event_fifo #(
        .WIDTH_REC (REC_W),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_grant),
        .push_data (w_push_data),
        .full      (w_full),
        .pop       (out_ready),
        .valid     (out_valid),
        .head_data (w_head),
        .count     (out_count)
    );

    assign out_chan = w_head[REC_W-1 -: CW];
    assign out_data = w_head[WIDTH-1:0];

`ifdef SENSE_EVENT_STATS_EN
    // A coalesce is an event landing on a channel whose previous value is
    // still pending and is not being pushed this cycle.
    logic [15:0] r_coal;
    logic [16:0] w_coal_sum;

    always_comb begin
        w_coal_sum = {1'b0, r_coal};
        for (int c = 0; c < CHANNELS; c++) begin
            w_coal_sum = w_coal_sum +
                17'(w_event[c] && r_pending[c] && !w_grant_vec[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_coal <= '0;
        end else begin
            r_coal <= w_coal_sum[16] ? 16'hFFFF : w_coal_sum[15:0];
        end
    end

    assign coal_count = r_coal;
`endif

endmodule
`default_nettype wire

// File: doc/sense_event_unit.md
# sense_event_unit

Parametrised multi-channel change-sense block: samples CHANNELS input groups of WIDTH bits each clock, detects per-channel events (any change, rising or falling, selected at run time), and queues one record per event in a DEPTH-entry FIFO drained over a valid/ready interface. It is the clocked, generalised successor to our combinational sensitivity-list modules. It sits between raw status inputs and any consumer that needs an ordered event stream instead of level outputs.

## Interface
- WIDTH, 2, bits per channel
- CHANNELS, 4, number of channels (≥2)
- DEPTH, 4, FIFO entries (power of two, ≥2)
- clk  input  1  clock; all logic on posedge
- rst  input  1  reset, synchronous, active-high
- in_data  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- mode  input  2  0 any-change, 1 rising, 2 falling, 3 disabled
- invert  input  1  record data is complemented when set
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- out_chan  output  $clog2(CHANNELS)  channel of head record
- out_data  output  WIDTH  data of head record
- out_count  output  $clog2(DEPTH)+1  FIFO occupancy
- coal_count  output  16  coalesced-event counter (SENSE_EVENT_STATS_EN only)

## Operation
- prev register holds last sample of in_data; updated every non-reset cycle.
- primed flag: cleared by rst, set on first non-reset edge; no events are detected while primed=0, so the first sample after reset never produces an event.
- Per-channel event (combinational, primed=1): mode 0: in≠prev; mode 1: any bit 0→1; mode 2: any bit 1→0; mode 3: none.
- pending[c] and pval[c] per channel: on event, pending[c]←1, pval[c]←in value XOR {WIDTH{invert}} (invert sampled with the event).
- Arbiter: lowest-index pending channel is granted when the FIFO is not full, or is full with a pop in the same cycle. Grant pushes {c, pval[c]} and clears pending[c].
- Same-cycle grant and new event on channel c: pending stays 1, pval takes the new value, and the granted record carries the old value.
- New event on a pending, ungranted channel: pval overwritten (latest wins). This is a coalesce.
- FIFO: head on out_chan/out_data; a pop occurs when out_valid&&out_ready; push and pop in the same cycle are both allowed when full; out_count changes by push−pop.
- Reset values: out_valid 0, out_count 0, out_chan 0, out_data 0, pending all 0, pval 0, prev 0, primed 0, coal_count 0. Reset mid-operation flushes the FIFO and pending state with no partial output.

## Timing
- Change presented before edge E is detected at E, and pending is set at E.
- Grant and push at E+1; out_valid is high after E+1. Minimum latency is 2 cycles input→record.
- Throughput is one push and one pop per cycle. With N channels firing together, records emerge in ascending channel order on consecutive cycles.
- mode and invert are sampled only at the detection edge; changes take effect at the next edge.
- out_* are registered FIFO outputs and hold stable while out_valid && !out_ready.

## Configuration
- SENSE_EVENT_STATS_EN defined: coal_count port exists and increments by the number of channels coalescing in a cycle. It saturates at 16'hFFFF and is cleared by rst.
- Not defined: port and counter absent; behaviour is otherwise identical.

## Structure
- Package sense_event_pkg: mode encoding constants (MODE_ANY, MODE_RISE, MODE_FALL, MODE_OFF) and function detect(prev, cur, mode) returning the event bit.
- One sub-module: sense_event_fifo (parametrised WIDTH_REC, DEPTH; push/full, pop/valid, count). Detection, pending and arbiter logic live in the top.

## Test plan
- Reset, then in_data=8'h00 held, then 8'h01 (ch0=01), mode 0 → one record {chan 0, data 2'b01} out_valid 2 cycles after the change; no record from the post-reset sample.
- mode 1, ch2 goes 2'b11→2'b10 then 2'b10→2'b11 → only the second change produces {2, 2'b11}; with invert=1 the record is {2, 2'b00}.
- out_ready=0, all 4 channels change together, DEPTH=4 → out_count reaches 4; records pop in order ch0,1,2,3 once out_ready=1.
- DEPTH=2, out_ready=0, ch0 and ch1 fill the FIFO, then ch3 changes twice → one ch3 record with the latest value after drain; coal_count=1 with SENSE_EVENT_STATS_EN.
- FIFO full with out_ready=1 and pending ch1 → push and pop in the same cycle; out_count stays at DEPTH.
- rst asserted for 1 cycle with 3 records queued and 2 channels pending → out_valid=0, out_count=0 on the next cycle, and no records appear afterwards until a new input change.
